// File: rtl/serial_parity_pkg.sv
// -----------------------------------------------------------------------------
// serial_parity_pkg
// Shared types and helpers for the serial parity framer family.
//   state_e     : framer FSM states (IDLE, SHIFT, PARITY)
//   MODE_ODD    : mode encoding for odd parity
//   MODE_EVEN   : mode encoding for even parity
//   parity_bit  : parity bit for a zero-extended word under a given mode
// -----------------------------------------------------------------------------
package serial_parity_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_e;

    localparam logic MODE_ODD  = 1'b1;
    localparam logic MODE_EVEN = 1'b0;

    // Widest word the helpers accept; narrower words are zero-extended.
    localparam int unsigned MAX_WIDTH = 32;

    // Odd mode returns ~^data, even mode returns ^data. Zero extension does
    // not change the reduction, so any width up to MAX_WIDTH works.
    function automatic logic parity_bit(input logic [MAX_WIDTH-1:0] data,
                                        input logic                 mode);
        return (^data) ^ mode;
    endfunction

endpackage

// File: rtl/parity_calc.sv
// -----------------------------------------------------------------------------
// parity_calc
// Combinational parity generator over a WIDTH-bit word with mode select.
// Shared by the framer and the future checker/deserialiser.
// Ports:
//   i_data   [WIDTH-1:0] in   word to reduce
//   i_odd               in   1 = odd parity, 0 = even parity
//   o_parity            out  parity bit for i_data under i_odd
// -----------------------------------------------------------------------------
module parity_calc
    import serial_parity_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_odd,
    output logic             o_parity
);

    logic [MAX_WIDTH-1:0] w_data_ext;

    assign w_data_ext = MAX_WIDTH'(i_data);
    assign o_parity   = parity_bit(w_data_ext, i_odd);

endmodule

// File: rtl/serial_parity_framer.sv
// -----------------------------------------------------------------------------
// serial_parity_framer
// Accepts a WIDTH-bit word over valid/ready and emits it LSB-first, one bit per
// beat, followed by a parity bit (odd or even, chosen per word). Downstream
// has valid/ready backpressure; a new word can be accepted on the parity beat
// so consecutive frames run with no idle cycle.
// Ports:
//   clk            in   system clock, rising edge
//   reset          in   asynchronous, active-high reset
//   ip_valid       in   ip_data/odd_mode valid
//   ip_ready       out  word can be accepted this cycle (combinational)
//   ip_data        in   parallel data word [WIDTH-1:0]
//   odd_mode       in   1 = odd parity, 0 = even; sampled with ip_data
//   op             out  serial output bit
//   op_valid       out  op is valid
//   op_ready       in   downstream accepts op this cycle
//   op_last        out  high on the parity beat
//   parity_mode_o  out  mode of frame in flight; DEFAULT_ODD when idle
//   busy           out  high while a frame is in flight
// -----------------------------------------------------------------------------
module serial_parity_framer
    import serial_parity_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter bit          DEFAULT_ODD = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ip_valid,
    output logic             ip_ready,
    input  logic [WIDTH-1:0] ip_data,
    input  logic             odd_mode,
    output logic             op,
    output logic             op_valid,
    input  logic             op_ready,
    output logic             op_last,
    output logic             parity_mode_o,
    output logic             busy
);

    localparam int unsigned      CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e           r_state,       w_state_next;
    logic [WIDTH-1:0] r_shift,       w_shift_next;
    logic [CNT_W-1:0] r_cnt,         w_cnt_next;
    logic             r_par_acc,     w_par_acc_next;
    logic             r_mode,        w_mode_next;
    logic             r_op,          w_op_next;
    logic             r_op_valid,    w_op_valid_next;
    logic             r_op_last,     w_op_last_next;
    logic             r_busy,        w_busy_next;
    logic             r_parity_mode, w_parity_mode_next;

    logic [WIDTH-1:0] w_shift_rsh;
    logic             w_ip_xor;
    logic             w_accept;
    logic             w_xfer;

    // Even-mode reduction gives the plain XOR of the incoming word; the frame's
    // mode is folded in only when the parity beat is formed.
    parity_calc #(
        .WIDTH (WIDTH)
    ) u_parity_calc (
        .i_data   (ip_data),
        .i_odd    (MODE_EVEN),
        .o_parity (w_ip_xor)
    );

    // Ready on the parity beat only if that beat transfers now, which frees the
    // shifter for the next word in the same edge.
    assign ip_ready    = (r_state == IDLE) || ((r_state == PARITY) && op_ready);
    assign w_accept    = ip_valid && ip_ready;
    assign w_xfer      = r_op_valid && op_ready;
    assign w_shift_rsh = r_shift >> 1;

    always_comb begin
        w_state_next       = r_state;
        w_shift_next       = r_shift;
        w_cnt_next         = r_cnt;
        w_par_acc_next     = r_par_acc;
        w_mode_next        = r_mode;
        w_op_next          = r_op;
        w_op_valid_next    = r_op_valid;
        w_op_last_next     = r_op_last;
        w_busy_next        = r_busy;
        w_parity_mode_next = r_parity_mode;

        case (r_state)
            IDLE: begin
                // Accept handled below.
            end

            SHIFT: begin
                if (w_xfer) begin
                    w_shift_next = w_shift_rsh;
                    w_cnt_next   = r_cnt + CNT_ONE;
                    if (r_cnt == LAST_IDX) begin
                        w_state_next   = PARITY;
                        w_op_next      = r_par_acc ^ r_mode;
                        w_op_last_next = 1'b1;
                    end else begin
                        w_op_next = w_shift_rsh[0];
                    end
                end
            end

            PARITY: begin
                if (w_xfer) begin
                    w_state_next       = IDLE;
                    w_shift_next       = '0;
                    w_cnt_next         = '0;
                    w_par_acc_next     = 1'b0;
                    w_mode_next        = DEFAULT_ODD;
                    w_op_next          = 1'b0;
                    w_op_valid_next    = 1'b0;
                    w_op_last_next     = 1'b0;
                    w_busy_next        = 1'b0;
                    w_parity_mode_next = DEFAULT_ODD;
                end
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase

        // A new word overrides whatever the parity beat would have done.
        if (w_accept) begin
            w_state_next       = SHIFT;
            w_shift_next       = ip_data;
            w_cnt_next         = '0;
            w_par_acc_next     = w_ip_xor;
            w_mode_next        = odd_mode;
            w_op_next          = ip_data[0];
            w_op_valid_next    = 1'b1;
            w_op_last_next     = 1'b0;
            w_busy_next        = 1'b1;
            w_parity_mode_next = odd_mode;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_shift       <= '0;
            r_cnt         <= '0;
            r_par_acc     <= 1'b0;
            r_mode        <= DEFAULT_ODD;
            r_op          <= 1'b0;
            r_op_valid    <= 1'b0;
            r_op_last     <= 1'b0;
            r_busy        <= 1'b0;
            r_parity_mode <= DEFAULT_ODD;
        end else begin
            r_state       <= w_state_next;
            r_shift       <= w_shift_next;
            r_cnt         <= w_cnt_next;
            r_par_acc     <= w_par_acc_next;
            r_mode        <= w_mode_next;
            r_op          <= w_op_next;
            r_op_valid    <= w_op_valid_next;
            r_op_last     <= w_op_last_next;
            r_busy        <= w_busy_next;
            r_parity_mode <= w_parity_mode_next;
        end
    end

    assign op            = r_op;
    assign op_valid      = r_op_valid;
    assign op_last       = r_op_last;
    assign busy          = r_busy;
    assign parity_mode_o = r_parity_mode;

endmodule

// File: tb/tb_serial_parity_framer.sv
// -----------------------------------------------------------------------------
// tb_serial_parity_framer
// Self-checking bench: an 8-bit framer checked every cycle against a queue of
// expected beats, plus a 3-bit framer swept over all inputs.
// -----------------------------------------------------------------------------
module tb_serial_parity_framer;

    localparam int unsigned W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         ip_valid, ip_ready, odd_mode;
    logic [W-1:0] ip_data;
    logic         op, op_valid, op_ready, op_last, parity_mode_o, busy;

    logic         ip_valid_3, ip_ready_3, odd_mode_3;
    logic [2:0]   ip_data_3;
    logic         op_3, op_valid_3, op_ready_3, op_last_3, parity_mode_3, busy_3;

    serial_parity_framer #(
        .WIDTH       (W),
        .DEFAULT_ODD (1'b1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ip_valid      (ip_valid),
        .ip_ready      (ip_ready),
        .ip_data       (ip_data),
        .odd_mode      (odd_mode),
        .op            (op),
        .op_valid      (op_valid),
        .op_ready      (op_ready),
        .op_last       (op_last),
        .parity_mode_o (parity_mode_o),
        .busy          (busy)
    );

    serial_parity_framer #(
        .WIDTH       (3),
        .DEFAULT_ODD (1'b0)
    ) dut3 (
        .clk           (clk),
        .reset         (reset),
        .ip_valid      (ip_valid_3),
        .ip_ready      (ip_ready_3),
        .ip_data       (ip_data_3),
        .odd_mode      (odd_mode_3),
        .op            (op_3),
        .op_valid      (op_valid_3),
        .op_ready      (op_ready_3),
        .op_last       (op_last_3),
        .parity_mode_o (parity_mode_3),
        .busy          (busy_3)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference parity from the bit count: odd mode makes the total ones odd.
    function automatic logic ref_parity(input logic [W-1:0] d, input logic m);
        return (($countones(d) % 2) == 0) ? m : ~m;
    endfunction

    typedef struct packed {
        logic b;
        logic last;
        logic mode;
    } beat_t;

    beat_t       exp_q[$];
    logic [63:0] obs_log;
    int          obs_n;
    int          busy_cnt;

    // Scoreboard: the queue holds every beat still owed downstream.
    always @(negedge clk) begin : mon
        logic exp_rdy;
        if (reset) begin
            exp_q.delete();
        end else begin
            check_eq("op_valid", op_valid, exp_q.size() != 0);
            check_eq("busy", busy, exp_q.size() != 0);
            if (exp_q.size() != 0) begin
                check_eq("op", op, exp_q[0].b);
                check_eq("op_last", op_last, exp_q[0].last);
                check_eq("parity_mode", parity_mode_o, exp_q[0].mode);
            end else begin
                check_eq("op_last_idle", op_last, 1'b0);
                check_eq("parity_mode_idle", parity_mode_o, 1'b1);
            end
            exp_rdy = (exp_q.size() == 0) || ((exp_q.size() == 1) && op_ready);
            check_eq("ip_ready", ip_ready, exp_rdy);
            if (busy) busy_cnt++;
            if ((exp_q.size() != 0) && op_ready) begin
                if (obs_n < 64) obs_log[obs_n] = op;
                obs_n++;
                void'(exp_q.pop_front());
            end
            if (ip_valid && exp_rdy) begin
                for (int i = 0; i < W; i++)
                    exp_q.push_back('{b: ip_data[i], last: 1'b0, mode: odd_mode});
                exp_q.push_back('{b: ref_parity(ip_data, odd_mode), last: 1'b1, mode: odd_mode});
            end
        end
    end

    task automatic clear_log();
        obs_log  = '0;
        obs_n    = 0;
        busy_cnt = 0;
    endtask

    task automatic send_word(input logic [W-1:0] d, input logic m);
        bit done;
        done     = 1'b0;
        ip_valid = 1'b1;
        ip_data  = d;
        odd_mode = m;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            if (ip_ready) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        ip_valid = 1'b0;
        if (!done) check_eq("accept_timeout", 0, 1);
    endtask

    task automatic wait_obs(input int n, input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(posedge clk);
            #1;
            if (obs_n >= n) done = 1'b1;
        end
        if (!done) check_eq("beat_timeout", obs_n, n);
    endtask

    task automatic wait_drain(input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) done = 1'b1;
        end
        if (!done) check_eq("drain_timeout", exp_q.size(), 0);
    endtask

    initial begin
        reset      = 1'b1;
        ip_valid   = 1'b0;
        ip_data    = '0;
        odd_mode   = 1'b0;
        op_ready   = 1'b0;
        ip_valid_3 = 1'b0;
        ip_data_3  = '0;
        odd_mode_3 = 1'b0;
        op_ready_3 = 1'b1;
        clear_log();
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        check_eq("rst_op", op, 1'b0);
        check_eq("rst_op_valid", op_valid, 1'b0);
        check_eq("rst_op_last", op_last, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_ip_ready", ip_ready, 1'b1);
        check_eq("rst_mode", parity_mode_o, 1'b1);
        check_eq("rst_mode_w3", parity_mode_3, 1'b0);
        reset = 1'b0;
        op_ready = 1'b1;
        @(posedge clk);
        #1;

        // 0xA5 odd and even, 0x00 odd and even
        clear_log();
        send_word(8'hA5, 1'b1);
        wait_drain(40);
        check_eq("a5_odd_bits", obs_log[8:0], 9'h1A5);
        check_eq("a5_odd_beats", obs_n, 9);
        check_eq("a5_odd_busy", busy_cnt, 9);

        clear_log();
        send_word(8'hA5, 1'b0);
        wait_drain(40);
        check_eq("a5_even_bits", obs_log[8:0], 9'h0A5);

        clear_log();
        send_word(8'h00, 1'b1);
        wait_drain(40);
        check_eq("z_odd_bits", obs_log[8:0], 9'h100);

        clear_log();
        send_word(8'h00, 1'b0);
        wait_drain(40);
        check_eq("z_even_bits", obs_log[8:0], 9'h000);

        // Back-to-back: 0xFF then 0x01, both odd, with no idle cycle between
        clear_log();
        send_word(8'hFF, 1'b1);
        send_word(8'h01, 1'b1);
        wait_drain(60);
        check_eq("b2b_bits", obs_log[17:0], {9'h001, 9'h1FF});
        check_eq("b2b_busy", busy_cnt, 18);

        // Backpressure for 3 cycles at beat 4 of 0x3C
        clear_log();
        send_word(8'h3C, 1'b1);
        wait_obs(4, 20);
        op_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_eq("stall_op", op, 1'b1);
            check_eq("stall_last", op_last, 1'b0);
            check_eq("stall_ready", ip_ready, 1'b0);
            check_eq("stall_valid", op_valid, 1'b1);
        end
        op_ready = 1'b1;
        wait_drain(40);
        check_eq("bp_bits", obs_log[8:0], 9'h13C);
        check_eq("bp_beats", obs_n, 9);
        check_eq("bp_busy", busy_cnt, 12);

        // Reset mid-frame, then 0x01 even
        clear_log();
        send_word(8'hA5, 1'b1);
        wait_obs(5, 20);
        reset = 1'b1;
        #1;
        check_eq("mid_rst_valid", op_valid, 1'b0);
        check_eq("mid_rst_busy", busy, 1'b0);
        check_eq("mid_rst_ready", ip_ready, 1'b1);
        check_eq("mid_rst_last", op_last, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_log();
        send_word(8'h01, 1'b0);
        wait_drain(40);
        check_eq("post_rst_bits", obs_log[8:0], 9'h101);

        // WIDTH=3 sweep in odd mode
        for (int v = 0; v < 8; v++) begin
            bit seen;
            seen       = 1'b0;
            check_eq("w3_ready", ip_ready_3, 1'b1);
            ip_valid_3 = 1'b1;
            ip_data_3  = 3'(v);
            odd_mode_3 = 1'b1;
            @(posedge clk);
            #1;
            ip_valid_3 = 1'b0;
            check_eq("w3_mode", parity_mode_3, 1'b1);
            for (int i = 0; i < 10 && !seen; i++) begin
                if (op_valid_3 && op_last_3) begin
                    seen = 1'b1;
                    check_eq("w3_parity", op_3, ref_parity(W'(v), 1'b1));
                end else begin
                    @(posedge clk);
                    #1;
                end
            end
            if (!seen) check_eq("w3_timeout", 0, 1);
            @(posedge clk);
            #1;
            check_eq("w3_idle", busy_3, 1'b0);
        end

        // Randomised traffic with backpressure and occasional reset
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 249) == 0) begin
                reset = 1'b1;
                #1;
                check_eq("rnd_rst_valid", op_valid, 1'b0);
                check_eq("rnd_rst_ready", ip_ready, 1'b1);
                @(posedge clk);
                #1;
                reset = 1'b0;
            end
            ip_valid = ($urandom_range(0, 2) != 0);
            ip_data  = W'($urandom);
            odd_mode = 1'($urandom);
            op_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        ip_valid = 1'b0;
        op_ready = 1'b1;
        wait_drain(64);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
